enc_quad_conditioner: RTL and testbench
=======================================

// Module: enc_quad_conditioner
// PURPOSE
//   Front end for one quadrature encoder channel pair, running on clk_fast.
//   - Synchronises the raw A/B pins and rejects glitches with a stable-sample filter.
//   - Decodes quadrature state changes into a direction bit, a per-edge tick pulse
//     and a wrapping position count.
//   - Clean a_out/b_out/dir feed the period-measurement stage directly downstream;
//     pos/err go to the board register file.
// PARAMETERS
//   FILT_LEN    4            consecutive clk_fast samples an input must hold before accepted (>=1)
//   POS_W       24           position counter width
//   POS_PRESET  24'h800000   position value after reset
// PORTS
//   clk_fast     in   1      fast sampling clock
//   reset        in   1      asynchronous, active-low
//   a_raw        in   1      encoder A pin (asynchronous)
//   b_raw        in   1      encoder B pin (asynchronous)
//   preset_load  in   1      1-cycle pulse: load pos from preset_val
//   preset_val   in   POS_W  value loaded on preset_load
//   err_clr      in   1      1-cycle pulse: clear sticky err
//   a_out        out  1      filtered A
//   b_out        out  1      filtered B
//   dir          out  1      0 = A leads B (Aup->Bup->Adn->Bdn), 1 = B leads A
//   tick         out  1      1-cycle pulse per accepted legal quadrature edge
//   pos          out  POS_W  position count
//   err          out  1      sticky: illegal transition (A and B changed same cycle)
// BEHAVIOUR
//   Reset (async, active-low): sync regs, filter counters, a_out, b_out, dir, tick, err = 0;
//     pos = POS_PRESET; init counter = 0.
//   Sync: 2-FF synchroniser per input; a_s/b_s valid 2 cycles after pin change.
//   Init: first 3 cycles after reset release, a_out<=a_s, b_out<=b_s directly;
//     no tick, no pos/dir/err update. Normal filtering/decoding starts on cycle 4.
//   Filter, per channel, counter width $clog2(FILT_LEN+1):
//     - x_s == x_out: counter cleared.
//     - x_s != x_out: counter increments; at FILT_LEN-1 -> x_out toggles next edge, counter cleared.
//     - Latency pin edge -> x_out edge = 2 + FILT_LEN cycles. Pulses shorter than
//       FILT_LEN samples are never accepted.
//   Decode: compares next {a_out,b_out} with current each cycle; outputs registered,
//     so tick/dir/pos change in the same cycle as a_out/b_out.
//     - Exactly one channel changes: tick=1.
//       * Forward (00->10->11->01->00 as {A,B}): dir=0, pos+1.
//       * Reverse: dir=1, pos-1.
//     - Both change same cycle: err=1, tick=0, dir and pos unchanged.
//     - No change: tick=0, dir holds.
//   Arithmetic: pos modulo 2^POS_W; all-ones +1 -> 0, 0 -1 -> all-ones; no saturation.
//   Simultaneous events:
//     - preset_load with legal edge: pos=preset_val (count lost); tick and dir still update.
//     - err_clr with illegal edge: err stays 1 (set wins).
//     - preset_load/err_clr during init: honoured.
//   Reset mid-operation: all state returns to reset values immediately; pulses in
//     flight are discarded; init sequence reruns after release.
// TESTING
//   1 FILT_LEN=4; hold a_raw=b_raw=1 through reset -> after init a_out=b_out=1,
//     pos=24'h800000, tick never asserted.
//   2 Forward cycle {A,B} 00->10->11->01->00, edges 20 cycles apart -> 4 ticks, each
//     6 cycles after pin edge; dir=0; pos=24'h800004. Reverse cycle -> dir=1, pos back to 24'h800000.
//   3 Glitch on a_raw, high 3 cycles -> a_out stays 0, no tick.
//     Repeat with 4 cycles -> accepted, one tick.
//   4 a_raw and b_raw toggle same cycle from 00 -> err=1, pos unchanged, no tick.
//     err_clr -> err=0. err_clr coincident with second illegal edge -> err stays 1.
//   5 preset_load, preset_val=24'hFFFFFF; one forward edge -> pos=0, then one reverse
//     edge -> pos=24'hFFFFFF. preset_load=24'h000010 coincident with tick -> pos=24'h000010, tick=1.
//   6 Assert reset mid-sequence while a filter counter is at 2 -> outputs immediately
//     at reset values; after release, init reloads a_out/b_out from pins with no tick.

Source files
------------

// File: rtl/enc_quad_if.sv
// Encoder channel bundle: raw pins and controls in, conditioned
// quadrature state, position and error flag out.
interface enc_quad_if #(
  parameter int POS_W = 24
);
  logic             a_raw;
  logic             b_raw;
  logic             preset_load;
  logic [POS_W-1:0] preset_val;
  logic             err_clr;
  logic             a_out;
  logic             b_out;
  logic             dir;
  logic             tick;
  logic [POS_W-1:0] pos;
  logic             err;

  modport master (
    output a_raw, b_raw,
    output preset_load, preset_val, err_clr,
    input  a_out, b_out, dir, tick, pos, err
  );

  modport slave (
    input  a_raw, b_raw,
    input  preset_load, preset_val, err_clr,
    output a_out, b_out, dir, tick, pos, err
  );
endinterface

// File: rtl/enc_quad_conditioner.sv
// Quadrature front end: synchronise, glitch-filter and decode A/B
// into direction, edge tick, wrapping position and sticky error.
module enc_quad_conditioner #(
  parameter int               FILT_LEN   = 4,
  parameter int               POS_W      = 24,
  parameter logic [POS_W-1:0] POS_PRESET = 24'h800000
) (
  input logic      clk_fast,
  input logic      reset,
  enc_quad_if.slave bus
);

  localparam int CW = $clog2(FILT_LEN + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(FILT_LEN - 1);

  logic             a_m_q, a_s_q;
  logic             b_m_q, b_s_q;
  logic [CW-1:0]    a_cnt_q, a_cnt_d;
  logic [CW-1:0]    b_cnt_q, b_cnt_d;
  logic             a_q, a_d;
  logic             b_q, b_d;
  logic             dir_q, dir_d;
  logic             tick_q, tick_d;
  logic             err_q, err_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [1:0]       init_q, init_d;
  logic             init_w;
  logic             chg_a, chg_b, fwd;

  always_comb begin
    init_w  = (init_q != 2'd3);
    init_d  = init_w ? init_q + 2'd1 : init_q;
    a_cnt_d = '0;
    b_cnt_d = '0;
    a_d     = a_q;
    b_d     = b_q;
    if (init_w) begin
      a_d = a_s_q;
      b_d = b_s_q;
    end else begin
      if (a_s_q != a_q) begin
        if (a_cnt_q == CNT_MAX) a_d = ~a_q;
        else a_cnt_d = a_cnt_q + CW'(1);
      end
      if (b_s_q != b_q) begin
        if (b_cnt_q == CNT_MAX) b_d = ~b_q;
        else b_cnt_d = b_cnt_q + CW'(1);
      end
    end
  end

  // Forward order 00->10->11->01: new A differs from old B
  always_comb begin
    chg_a  = (a_d ^ a_q) & ~init_w;
    chg_b  = (b_d ^ b_q) & ~init_w;
    fwd    = a_d ^ b_q;
    tick_d = 1'b0;
    dir_d  = dir_q;
    pos_d  = pos_q;
    err_d  = err_q & ~bus.err_clr;
    unique case (1'b1)
      chg_a & chg_b: err_d = 1'b1;
      chg_a ^ chg_b: begin
        tick_d = 1'b1;
        dir_d  = ~fwd;
        pos_d  = fwd ? pos_q + POS_W'(1)
                     : pos_q - POS_W'(1);
      end
      default: ;
    endcase
    if (bus.preset_load) pos_d = bus.preset_val;
  end

  always_ff @(posedge clk_fast or negedge reset) begin
    if (!reset) begin
      a_m_q   <= 1'b0;
      a_s_q   <= 1'b0;
      b_m_q   <= 1'b0;
      b_s_q   <= 1'b0;
      a_cnt_q <= '0;
      b_cnt_q <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      dir_q   <= 1'b0;
      tick_q  <= 1'b0;
      err_q   <= 1'b0;
      pos_q   <= POS_PRESET;
      init_q  <= 2'd0;
    end else begin
      a_m_q   <= bus.a_raw;
      a_s_q   <= a_m_q;
      b_m_q   <= bus.b_raw;
      b_s_q   <= b_m_q;
      a_cnt_q <= a_cnt_d;
      b_cnt_q <= b_cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      dir_q   <= dir_d;
      tick_q  <= tick_d;
      err_q   <= err_d;
      pos_q   <= pos_d;
      init_q  <= init_d;
    end
  end

  assign bus.a_out = a_q;
  assign bus.b_out = b_q;
  assign bus.dir   = dir_q;
  assign bus.tick  = tick_q;
  assign bus.err   = err_q;
  assign bus.pos   = pos_q;

endmodule

// File: tb/tb_enc_quad_conditioner.sv
// Bench for enc_quad_conditioner: vector table for the quadrature walk
// plus hand sequences for glitch, preset, error and reset corners.
module tb_enc_quad_conditioner;

  logic clk;
  logic reset;
  int   cyc;
  int   tests;
  int   fails;

  enc_quad_if #(.POS_W(24)) bus ();

  enc_quad_conditioner #(
    .FILT_LEN  (4),
    .POS_W     (24),
    .POS_PRESET(24'h800000)
  ) dut (
    .clk_fast(clk),
    .reset   (reset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic        dir;
    logic [23:0] pos;
  } exp_t;

  typedef struct {
    logic        a;
    logic        b;
    logic        clr;
    logic        tick;
    logic        dir;
    logic [23:0] pos;
    logic        err;
  } vec_t;

  exp_t q[$];
  vec_t vecs[10];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic push_tick(input logic d, input logic [23:0] p);
    exp_t e;
    e.due = cyc + 6;
    e.dir = d;
    e.pos = p;
    q.push_back(e);
  endtask

  // Scoreboard: match every observed tick against the queue head
  task automatic sample();
    exp_t e;
    if (bus.tick === 1'b1) begin
      if (q.size() == 0) begin
        chk("spurious_tick", bus.tick, 1'b0);
      end else begin
        e = q.pop_front();
        chk("tick_cycle", cyc, e.due);
        chk("tick_dir", bus.dir, e.dir);
        chk("tick_pos", bus.pos, e.pos);
      end
    end else if (q.size() > 0 && cyc >= q[0].due) begin
      e = q.pop_front();
      chk("missed_tick", bus.tick, 1'b1);
    end
  endtask

  task automatic cyc_wait(input int n);
    repeat (n) begin
      @(negedge clk);
      sample();
    end
  endtask

  task automatic chk_state(input string tag,
                           input logic a, input logic b,
                           input logic d, input logic [23:0] p,
                           input logic e);
    chk({tag, "_a_out"}, bus.a_out, a);
    chk({tag, "_b_out"}, bus.b_out, b);
    chk({tag, "_dir"}, bus.dir, d);
    chk({tag, "_pos"}, bus.pos, p);
    chk({tag, "_err"}, bus.err, e);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 24'h800001, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 24'h800002, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 24'h800003, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 24'h800004, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 24'h800003, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 24'h800002, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 24'h800001, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 24'h800000, 1'b0};
    vecs[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 24'h800000, 1'b1};
    vecs[9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 24'h800000, 1'b0};

    reset = 1'b0;
    bus.a_raw = 1'b1;
    bus.b_raw = 1'b1;
    bus.preset_load = 1'b0;
    bus.preset_val = '0;
    bus.err_clr = 1'b0;

    // Pins high through reset, then init loads them
    cyc_wait(3);
    chk("rst_tick", bus.tick, 1'b0);
    chk_state("rst", 1'b0, 1'b0, 1'b0, 24'h800000, 1'b0);
    reset = 1'b1;
    cyc_wait(10);
    chk("init_tick", bus.tick, 1'b0);
    chk_state("init11", 1'b1, 1'b1, 1'b0, 24'h800000, 1'b0);

    reset = 1'b0;
    bus.a_raw = 1'b0;
    bus.b_raw = 1'b0;
    cyc_wait(3);
    reset = 1'b1;
    cyc_wait(10);
    chk_state("init00", 1'b0, 1'b0, 1'b0, 24'h800000, 1'b0);

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].tick) push_tick(vecs[i].dir, vecs[i].pos);
      bus.a_raw = vecs[i].a;
      bus.b_raw = vecs[i].b;
      if (vecs[i].clr) begin
        bus.err_clr = 1'b1;
        cyc_wait(1);
        bus.err_clr = 1'b0;
        cyc_wait(19);
      end else begin
        cyc_wait(20);
      end
      chk_state($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                vecs[i].dir, vecs[i].pos, vecs[i].err);
    end

    // Illegal edge with err_clr on the same cycle: set wins
    bus.a_raw = 1'b0;
    bus.b_raw = 1'b0;
    cyc_wait(5);
    bus.err_clr = 1'b1;
    cyc_wait(1);
    bus.err_clr = 1'b0;
    chk("clr_vs_set_err", bus.err, 1'b1);
    cyc_wait(14);
    chk_state("ill2", 1'b0, 1'b0, 1'b1, 24'h800000, 1'b1);

    // Three-sample glitch is rejected
    bus.a_raw = 1'b1;
    cyc_wait(3);
    bus.a_raw = 1'b0;
    cyc_wait(17);
    chk("glitch3_a_out", bus.a_out, 1'b0);
    chk("glitch3_pos", bus.pos, 24'h800000);

    // Four-sample pulse is accepted, then falls back
    push_tick(1'b0, 24'h800001);
    bus.a_raw = 1'b1;
    cyc_wait(4);
    push_tick(1'b1, 24'h800000);
    bus.a_raw = 1'b0;
    cyc_wait(3);
    chk("pulse4_a_out_hi", bus.a_out, 1'b1);
    cyc_wait(13);
    chk_state("pulse4", 1'b0, 1'b0, 1'b1, 24'h800000, 1'b1);

    // Preset near the top and wrap both ways
    bus.preset_val = 24'hFFFFFF;
    bus.preset_load = 1'b1;
    cyc_wait(1);
    bus.preset_load = 1'b0;
    cyc_wait(2);
    chk("preset_pos", bus.pos, 24'hFFFFFF);
    push_tick(1'b0, 24'h000000);
    bus.a_raw = 1'b1;
    cyc_wait(20);
    chk("wrap_up_pos", bus.pos, 24'h000000);
    push_tick(1'b1, 24'hFFFFFF);
    bus.a_raw = 1'b0;
    cyc_wait(20);
    chk("wrap_dn_pos", bus.pos, 24'hFFFFFF);
    chk("wrap_dn_dir", bus.dir, 1'b1);

    // Preset coincident with a legal edge overrides the count
    push_tick(1'b0, 24'h000010);
    bus.a_raw = 1'b1;
    cyc_wait(5);
    bus.preset_val = 24'h000010;
    bus.preset_load = 1'b1;
    cyc_wait(1);
    bus.preset_load = 1'b0;
    cyc_wait(14);
    chk_state("preset_tick", 1'b1, 1'b0, 1'b0, 24'h000010, 1'b1);

    // Reset while the A filter counter sits at 2
    bus.a_raw = 1'b0;
    cyc_wait(4);
    reset = 1'b0;
    #1;
    chk("midrst_tick", bus.tick, 1'b0);
    chk_state("midrst", 1'b0, 1'b0, 1'b0, 24'h800000, 1'b0);
    bus.b_raw = 1'b1;
    cyc_wait(3);
    reset = 1'b1;
    cyc_wait(10);
    chk_state("reinit", 1'b0, 1'b1, 1'b0, 24'h800000, 1'b0);
    chk("sb_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
